pipe_gen: RTL and testbench

PIPE_GEN -- requirements
Module: pipe_gen

---
 rtl/pipe_gen.sv | 142 ++++++++++++++
 tb/tb_pipe_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_gen.sv
// Pipe generator for a side-scrolling game: two pipes scroll left, respawn on the right
// with an LFSR-chosen gap height, and scroll speed rises every eight respawns.
module pipe_gen #(
    parameter int SPACING    = 340,
    parameter int X_START1   = 660,
    parameter int X_WRAP     = 20,
    parameter int Y_BASE     = 48,
    parameter int SPEED_INIT = 2,
    parameter int SPEED_MAX  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       FrameTick,
    input  logic       q_I,
    input  logic       q_EN,
    input  logic       q_End,
    output logic [9:0] XPipe1,
    output logic [9:0] XPipe2,
    output logic [9:0] YPipe1,
    output logic [9:0] YPipe2,
    output logic [2:0] Speed,
    output logic       Respawn
);

    localparam logic [9:0] X_START1_W   = 10'(X_START1);
    localparam logic [9:0] X_START2_W   = 10'(X_START1 + SPACING);
    localparam logic [9:0] X_WRAP_W     = 10'(X_WRAP);
    localparam logic [9:0] SPACING2_W   = 10'(2 * SPACING);
    localparam logic [9:0] Y_BASE_W     = 10'(Y_BASE);
    // Gap position shown before the first IDLE cycle has sampled the LFSR.
    localparam logic [9:0] Y_RST_W      = 10'(Y_BASE + 120);
    localparam logic [2:0] SPEED_INIT_W = 3'(SPEED_INIT);
    localparam logic [2:0] SPEED_MAX_W  = 3'(SPEED_MAX);
    localparam logic [7:0] LFSR_SEED    = 8'hA5;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [9:0] x1_q, x1_d, x2_q, x2_d;
    logic [9:0] y1_q, y1_d, y2_q, y2_d;
    logic [2:0] speed_q, speed_d;
    logic [2:0] cnt_q, cnt_d;
    logic       respawn_q, respawn_d;
    logic [10:0] step1, step2;

    // x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [2:0] speed_step(input logic [2:0] s);
        return (s < SPEED_MAX_W) ? s + 3'd1 : s;
    endfunction

    // Returns {wrapped, new_x}; a wrapped pipe reappears two spacings to the right.
    function automatic logic [10:0] pipe_step(input logic [9:0] x, input logic [9:0] spd);
        if (x >= X_WRAP_W + spd) return {1'b0, x - spd};
        else                     return {1'b1, x - spd + SPACING2_W};
    endfunction

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_next(lfsr_q);
        x1_d      = x1_q;
        x2_d      = x2_q;
        y1_d      = y1_q;
        y2_d      = y2_q;
        speed_d   = speed_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;
        step1     = pipe_step(x1_q, {7'd0, speed_q});
        step2     = pipe_step(x2_q, {7'd0, speed_q});
        case (state_q)
            IDLE: begin
                x1_d    = X_START1_W;
                x2_d    = X_START2_W;
                speed_d = SPEED_INIT_W;
                cnt_d   = 3'd0;
                y1_d    = Y_BASE_W + {2'b00, lfsr_q};
                y2_d    = Y_BASE_W + {2'b00, bit_rev8(lfsr_q)};
                if (q_EN) state_d = RUN;
            end
            RUN: begin
                if (FrameTick) begin
                    x1_d = step1[9:0];
                    x2_d = step2[9:0];
                    if (step1[10]) y1_d = Y_BASE_W + {2'b00, lfsr_q};
                    if (step2[10]) y2_d = Y_BASE_W + {2'b00, lfsr_q};
                    // Simultaneous respawns still count as one event.
                    if (step1[10] || step2[10]) begin
                        respawn_d = 1'b1;
                        cnt_d     = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) speed_d = speed_step(speed_q);
                    end
                end
                if (q_End) state_d = HOLD;
            end
            HOLD: ;
            default: state_d = IDLE;
        endcase
        if (q_I) state_d = IDLE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            x1_q      <= X_START1_W;
            x2_q      <= X_START2_W;
            y1_q      <= Y_RST_W;
            y2_q      <= Y_RST_W;
            speed_q   <= SPEED_INIT_W;
            cnt_q     <= 3'd0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            y1_q      <= y1_d;
            y2_q      <= y2_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            respawn_q <= respawn_d;
        end
    end

    assign XPipe1  = x1_q;
    assign XPipe2  = x2_q;
    assign YPipe1  = y1_q;
    assign YPipe2  = y2_q;
    assign Speed   = speed_q;
    assign Respawn = respawn_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Bench for pipe_gen: directed phases with randomized frame ticks, compared every cycle
// against an arithmetic reference model of the game rules.
module tb_pipe_gen;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       FrameTick = 1'b0, q_I = 1'b0, q_EN = 1'b0, q_End = 1'b0;
    logic [9:0] XPipe1, XPipe2, YPipe1, YPipe2;
    logic [2:0] Speed;
    logic       Respawn;

    int checks = 0;
    int errors = 0;

    pipe_gen dut (
        .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .q_I(q_I), .q_EN(q_EN),
        .q_End(q_End), .XPipe1(XPipe1), .XPipe2(XPipe2), .YPipe1(YPipe1),
        .YPipe2(YPipe2), .Speed(Speed), .Respawn(Respawn)
    );

    always #5 Clk = ~Clk;

    // Reference model: 0 = idle, 1 = run, 2 = hold.
    int         m_mode;
    logic [7:0] m_rand;
    int         mx[2], my[2];
    int         m_spd, m_respawns, m_resp;

    function automatic int rev8(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r += 1 << (7 - i);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_rand = 8'hA5;
        mx[0] = 660; mx[1] = 1000; my[0] = 168; my[1] = 168;
        m_spd = 2; m_respawns = 0; m_resp = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".x1"}, 32'(XPipe1), 32'(mx[0]));
        chk({tag, ".x2"}, 32'(XPipe2), 32'(mx[1]));
        chk({tag, ".y1"}, 32'(YPipe1), 32'(my[0]));
        chk({tag, ".y2"}, 32'(YPipe2), 32'(my[1]));
        chk({tag, ".speed"}, 32'(Speed), 32'(m_spd));
        chk({tag, ".respawn"}, 32'(Respawn), 32'(m_resp));
    endtask

    // One clock: apply inputs, advance the model by the game rules, compare after the edge.
    task automatic step(input logic ft, input logic en, input logic fin, input logic init);
        int n_mode;
        int nx[2], ny[2];
        int n_spd, n_resp, n_respawns;
        logic [7:0] n_rand;
        bit hit;
        FrameTick = ft; q_EN = en; q_End = fin; q_I = init;
        n_mode = m_mode; nx = mx; ny = my; n_spd = m_spd;
        n_respawns = m_respawns; n_resp = 0; hit = 0;
        n_rand = {m_rand[6:0], ^(m_rand & 8'hB8)};
        if (m_mode == 0) begin
            nx[0] = 660; nx[1] = 1000; n_spd = 2; n_respawns = 0;
            ny[0] = 48 + int'(m_rand); ny[1] = 48 + rev8(m_rand);
            if (en) n_mode = 1;
        end else if (m_mode == 1) begin
            if (ft) begin
                for (int p = 0; p < 2; p++) begin
                    if (mx[p] >= 20 + m_spd) nx[p] = mx[p] - m_spd;
                    else begin
                        nx[p] = mx[p] - m_spd + 680;
                        ny[p] = 48 + int'(m_rand);
                        hit = 1;
                    end
                end
                if (hit) begin
                    n_resp = 1;
                    n_respawns = m_respawns + 1;
                    if (n_respawns % 8 == 0 && n_spd < 4) n_spd++;
                end
            end
            if (fin) n_mode = 2;
        end
        if (init) n_mode = 0;
        @(posedge Clk);
        m_mode = n_mode; mx = nx; my = ny; m_spd = n_spd;
        m_respawns = n_respawns; m_resp = n_resp; m_rand = n_rand;
        #1;
        check_all("cycle");
    endtask

    initial begin
        int seen;
        int budget;
        logic [9:0] hx1, hx2, hy1, hy2;
        logic [2:0] hspd;
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 Reset = 1'b0;
        #1;
        chk("rst.x1", 32'(XPipe1), 660);
        chk("rst.x2", 32'(XPipe2), 1000);
        chk("rst.y1", 32'(YPipe1), 168);
        chk("rst.y2", 32'(YPipe2), 168);
        chk("rst.speed", 32'(Speed), 2);
        chk("rst.respawn", 32'(Respawn), 0);
        @(posedge Clk); #1;
        Reset = 1'b1;

        // Idle with init asserted; frame ticks and a competing q_EN must do nothing.
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(0, 0, 1, 1);
        step(1, 0, 0, 0);
        chk("idle.x1", 32'(XPipe1), 660);
        chk("idle.x2", 32'(XPipe2), 1000);
        chk("idle.speed", 32'(Speed), 2);
        chk("idle.y1_range", 32'(YPipe1 >= 10'd48 && YPipe1 <= 10'd303), 1);
        chk("idle.y2_range", 32'(YPipe2 >= 10'd48 && YPipe2 <= 10'd303), 1);

        // Enter run, then ten frame ticks with random idle cycles in between.
        step(0, 1, 0, 0);
        seen = 0;
        while (seen < 10) begin
            if ($urandom_range(0, 2) != 0) begin step(1, 0, 0, 0); seen++; end
            else step(0, 0, 0, 0);
        end
        chk("ten_ticks.x1", 32'(XPipe1), 640);
        chk("ten_ticks.x2", 32'(XPipe2), 980);
        chk("ten_ticks.respawn", 32'(Respawn), 0);

        // Run to the first wrap of pipe 1.
        budget = 0;
        while (Respawn !== 1'b1 && budget < 2000) begin step(1, 0, 0, 0); budget++; end
        chk("first_wrap.seen", 32'(Respawn), 1);
        chk("first_wrap.x1", 32'(XPipe1), 698);
        chk("first_wrap.x2", 32'(XPipe2), 358);
        chk("first_wrap.spacing", 32'(XPipe1 - XPipe2), 340);
        step(0, 0, 0, 0);
        chk("first_wrap.pulse_end", 32'(Respawn), 0);

        // Speed ramp: +1 per 8 respawns, saturating at 4.
        seen = 1; budget = 0;
        while (seen < 32 && budget < 40000) begin
            step(1'($urandom_range(0, 3) != 0), 0, 0, 0);
            budget++;
            if (Respawn === 1'b1) begin
                seen++;
                if (seen == 8)  chk("ramp.speed_after_8", 32'(Speed), 3);
                if (seen == 24) chk("ramp.speed_after_24", 32'(Speed), 4);
            end
        end
        chk("ramp.respawn_count", 32'(seen), 32);
        chk("ramp.speed_saturated", 32'(Speed), 4);

        // Hold freezes everything; init then restores the start position.
        step(0, 0, 1, 0);
        hx1 = 10'(mx[0]); hx2 = 10'(mx[1]); hy1 = 10'(my[0]); hy2 = 10'(my[1]);
        hspd = 3'(m_spd);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        chk("hold.x1", 32'(XPipe1), 32'(hx1));
        chk("hold.x2", 32'(XPipe2), 32'(hx2));
        chk("hold.y1", 32'(YPipe1), 32'(hy1));
        chk("hold.y2", 32'(YPipe2), 32'(hy2));
        chk("hold.speed", 32'(Speed), 32'(hspd));
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("reinit.x1", 32'(XPipe1), 660);
        chk("reinit.speed", 32'(Speed), 2);

        // Run again and hit the asynchronous reset between clock edges.
        step(0, 1, 0, 0);
        for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 0, 0, 0);
        #3 Reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst.x1", 32'(XPipe1), 660);
        chk("async_rst.x2", 32'(XPipe2), 1000);
        chk("async_rst.y1", 32'(YPipe1), 168);
        chk("async_rst.y2", 32'(YPipe2), 168);
        chk("async_rst.speed", 32'(Speed), 2);
        chk("async_rst.respawn", 32'(Respawn), 0);
        @(posedge Clk); #1;
        check_all("in_reset");
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
